// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the trailing XOR checksum byte).
package imem_loader_pkg;

   // Width of the little-endian word-count field that follows the sync byte.
   localparam int LEN_W = 16;

   // Default frame start marker.
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Loader states. CSUM exists only when the checksum byte is part of the frame.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN0 = 3'd1,
      ST_LEN1 = 3'd2,
      ST_DATA = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM = 3'd4,
`endif
      ST_RUN  = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four consecutive payload bytes into one little-endian 32-bit word.
// The word and its completion pulse are presented combinationally with the
// fourth byte so the parent can register the RAM write on that same edge.
module word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_done,
   output logic [31:0] word
);

   logic [1:0]  byte_idx;
   logic [23:0] low_bytes;

   // Track the byte position within the word and hold b0..b2 until b3 arrives.
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         byte_idx  <= '0;
         low_bytes <= '0;
      end else if (byte_valid) begin
         byte_idx  <= byte_idx + 2'd1;
         // Newest byte enters at the top, so after b2 the register reads {b2,b1,b0}.
         low_bytes <= {byte_data, low_bytes[23:8]};
      end
   end

   assign word_done = byte_valid && (byte_idx == 2'd3);
   assign word      = {byte_data, low_bytes};

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a framed byte stream, writes the payload
// words into instruction RAM and holds the core in reset until a complete,
// well-formed frame has landed.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte
// verified before release; without it the frame ends with the last data word).
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         ADDR_W    = 6,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wd,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   // Word index carries one extra bit so a full 2^ADDR_W-word frame can be counted.
   localparam int IDX_W = ADDR_W + 1;

   // Largest legal word count, 2^ADDR_W, held one bit wider than the count field.
   localparam logic [LEN_W:0] MAX_WORDS = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

   // Where the frame goes once the payload (possibly empty) has been consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t ST_AFTER_DATA = ST_CSUM;
`else
   localparam state_t ST_AFTER_DATA = ST_RUN;
`endif

   state_t            state;
   state_t            state_next;

   logic              hs;
   logic              data_hs;
   logic              is_sync;
   logic [7:0]        count_lo;
   logic [LEN_W-1:0]  frame_len;
   logic [LEN_W-1:0]  word_cnt;
   logic [IDX_W-1:0]  word_idx;
   logic              last_word;
   logic              run_q;
   logic              release_go;

   logic              asm_clear;
   logic              word_done;
   logic [31:0]       asm_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        xor_acc;
`endif

   assign hs        = in_valid && in_ready;
   assign data_hs   = hs && (state == ST_DATA);
   assign is_sync   = (in_data == SYNC_BYTE);
   assign frame_len = {in_data, count_lo};
   assign last_word = (LEN_W'(word_idx) + LEN_W'(1)) == word_cnt;

   // Byte position restarts whenever the loader is not inside the payload.
   assign asm_clear = (state != ST_DATA);

   word_assembler u_word_assembler (
      .clk        (clk),
      .reset      (reset),
      .clear      (asm_clear),
      .byte_valid (data_hs),
      .byte_data  (in_data),
      .word_done  (word_done),
      .word       (asm_word)
   );

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: every clocked assignment is non-blocking so all registers update
      // from the same pre-edge values, independent of statement order.
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode from the current state and the accepted byte.
   always_comb begin
      // NOTE: the default here covers every path, so no latch is inferred.
      state_next = state;
      unique case (state)
         ST_IDLE, ST_RUN, ST_ERR: begin
            if (hs && is_sync) begin
               state_next = ST_LEN0;
            end
         end
         ST_LEN0: begin
            if (hs) begin
               state_next = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (hs) begin
               if ({1'b0, frame_len} > MAX_WORDS) begin
                  state_next = ST_ERR;
               end else if (frame_len == '0) begin
                  state_next = ST_AFTER_DATA;
               end else begin
                  state_next = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (word_done && last_word) begin
               state_next = ST_AFTER_DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (hs) begin
               state_next = (in_data == xor_acc) ? ST_RUN : ST_ERR;
            end
         end
`endif
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Frame length capture, word indexing and the registered RAM write port.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_lo  <= '0;
         word_cnt  <= '0;
         word_idx  <= '0;
         imem_we   <= 1'b0;
         imem_addr <= '0;
         imem_wd   <= '0;
      end else begin
         imem_we <= 1'b0;
         if (hs && (state == ST_LEN0)) begin
            count_lo <= in_data;
         end
         if (hs && (state == ST_LEN1)) begin
            word_cnt <= frame_len;
         end
         if (state_next == ST_LEN0) begin
            word_idx <= '0;
         end else if (word_done) begin
            imem_we   <= 1'b1;
            imem_addr <= word_idx[ADDR_W-1:0];
            imem_wd   <= asm_word;
            word_idx  <= word_idx + IDX_W'(1);
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Running XOR over payload bytes only; restarted by every sync byte.
   always_ff @(posedge clk) begin
      if (!reset) begin
         xor_acc <= '0;
      end else if (state_next == ST_LEN0) begin
         xor_acc <= '0;
      end else if (data_hs) begin
         xor_acc <= xor_acc ^ in_data;
      end
   end
`endif

   // Core release is held back one extra cycle after RUN is entered so the
   // final RAM write has landed before the core fetches from address 0.
   assign release_go = (state == ST_RUN) && run_q;

   // Status outputs and the stream ready flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_ready  <= 1'b0;
         run_q     <= 1'b0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         in_ready  <= 1'b1;
         run_q     <= (state == ST_RUN);
         cpu_reset <= !release_go;
         done      <= release_go;
         error     <= (state_next == ST_ERR);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader. Follows IMEM_LOADER_CHECKSUM_EN
// so the same stimulus matches either build of the loader.
`timescale 1ns/1ps
module tb_imem_loader;

   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wd;
   logic              cpu_reset;
   logic              done;
   logic              error;

   int checks = 0;
   int errors = 0;
   bit stream_gap = 1'b0;

   logic [31:0] ram [0:63];
   int          we_count = 0;

   imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wd   (imem_wd),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   // Behavioural instruction RAM on the loader's write port.
   always @(posedge clk) begin
      if (imem_we) begin
         ram[imem_addr] <= imem_wd;
         we_count       <= we_count + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte; returns 1 ns after the accepting edge. Bounded wait.
   task automatic send_byte(input logic [7:0] b);
      logic took;
      took = 1'b0;
      if (stream_gap) tick();
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 16 && !took; i++) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!took) begin
         checks++;
         errors++;
         $display("FAIL handshake: in_ready=0 for 16 cycles on byte %h, required 1", b);
      end
   endtask

   // Full frame: sync, count, payload and (when built in) the correct checksum.
   task automatic send_frame(input logic [31:0] w[$]);
      logic [15:0] n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [7:0] x;
      x = 8'h00;
`endif
      n = 16'(w.size());
      send_byte(8'hA5);
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      foreach (w[i]) begin
         for (int k = 0; k < 4; k++) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            x ^= w[i][8*k +: 8];
`endif
            send_byte(w[i][8*k +: 8]);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(x);
`endif
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if ({in_ready, imem_we, imem_addr, imem_wd, cpu_reset, done, error} !==
          {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: rdy=%b we=%b addr=%0d wd=%h cpu_reset=%b done=%b error=%b, required 0 0 0 0 1 0 0",
                  in_ready, imem_we, imem_addr, imem_wd, cpu_reset, done, error);
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({in_ready, cpu_reset, done} !== 3'b110) begin
         errors++;
         $display("FAIL ready_after_reset: {in_ready,cpu_reset,done}=%b, required 110", {in_ready, cpu_reset, done});
      end
   endtask

   task automatic test_load();
      logic [7:0] head [7];
      head = '{8'hA5, 8'h02, 8'h00, 8'h03, 8'h00, 8'hA0, 8'hE3};
      foreach (head[i]) send_byte(head[i]);
      checks++;
      if ({imem_we, imem_addr, imem_wd} !== {1'b1, 6'd0, 32'hE3A00003}) begin
         errors++;
         $display("FAIL write_word0: we=%b addr=%0d wd=%h, required 1 0 e3a00003", imem_we, imem_addr, imem_wd);
      end
      send_byte(8'h04);
      checks++;
      if (imem_we !== 1'b0) begin
         errors++;
         $display("FAIL we_one_cycle: imem_we=%b, required 0", imem_we);
      end
      send_byte(8'h10);
      send_byte(8'h80);
      send_byte(8'hE2);
      checks++;
      if ({imem_we, imem_addr, imem_wd} !== {1'b1, 6'd1, 32'hE2801004}) begin
         errors++;
         $display("FAIL write_word1: we=%b addr=%0d wd=%h, required 1 1 e2801004", imem_we, imem_addr, imem_wd);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h36);
`endif
      checks++;
      if ({cpu_reset, done, error} !== 3'b100) begin
         errors++;
         $display("FAIL release_edge0: {cpu_reset,done,error}=%b, required 100", {cpu_reset, done, error});
      end
      tick();
      checks++;
      if ({cpu_reset, done} !== 2'b10) begin
         errors++;
         $display("FAIL release_edge1: {cpu_reset,done}=%b, required 10", {cpu_reset, done});
      end
      tick();
      checks++;
      if ({cpu_reset, done, error} !== 3'b010) begin
         errors++;
         $display("FAIL release_edge2: {cpu_reset,done,error}=%b, required 010", {cpu_reset, done, error});
      end
      checks++;
      if (ram[0] !== 32'hE3A00003 || ram[1] !== 32'hE2801004) begin
         errors++;
         $display("FAIL load_ram: ram0=%h ram1=%h, required e3a00003 e2801004", ram[0], ram[1]);
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_bad_checksum();
      logic [7:0] bad [12];
      bad = '{8'hA5, 8'h02, 8'h00, 8'h03, 8'h00, 8'hA0, 8'hE3, 8'h04, 8'h10, 8'h80, 8'hE2, 8'hC9};
      foreach (bad[i]) send_byte(bad[i]);
      checks++;
      if ({cpu_reset, done, error} !== 3'b101) begin
         errors++;
         $display("FAIL bad_csum_error: {cpu_reset,done,error}=%b, required 101", {cpu_reset, done, error});
      end
      repeat (3) tick();
      checks++;
      if ({cpu_reset, done, error} !== 3'b101) begin
         errors++;
         $display("FAIL bad_csum_hold: {cpu_reset,done,error}=%b, required 101", {cpu_reset, done, error});
      end
      send_frame('{32'hE3A00003, 32'hE2801004});
      tick();
      tick();
      checks++;
      if ({cpu_reset, done, error} !== 3'b010) begin
         errors++;
         $display("FAIL recover_after_error: {cpu_reset,done,error}=%b, required 010", {cpu_reset, done, error});
      end
   endtask
`endif

   task automatic test_count_bounds();
      int            we0;
      logic [31:0]   big [$];
      we0 = we_count;
      send_byte(8'hA5);
      send_byte(8'h41);
      send_byte(8'h00);
      checks++;
      if ({cpu_reset, done, error} !== 3'b101) begin
         errors++;
         $display("FAIL oversize_error: {cpu_reset,done,error}=%b, required 101", {cpu_reset, done, error});
      end
      repeat (3) tick();
      checks++;
      if (we_count !== we0) begin
         errors++;
         $display("FAIL oversize_no_write: imem_we pulses=%0d, required 0", we_count - we0);
      end
      for (int i = 0; i < 64; i++) big.push_back({8'(i), 8'hC3, 8'(63 - i), 8'h5A});
      send_frame(big);
      tick();
      tick();
      checks++;
      if ({cpu_reset, done, error} !== 3'b010) begin
         errors++;
         $display("FAIL full_frame_release: {cpu_reset,done,error}=%b, required 010", {cpu_reset, done, error});
      end
      checks++;
      if (we_count - we0 !== 64 || ram[0] !== 32'h00C33F5A || ram[63] !== 32'h3FC3005A) begin
         errors++;
         $display("FAIL full_frame_ram: writes=%0d ram0=%h ram63=%h, required 64 00c33f5a 3fc3005a",
                  we_count - we0, ram[0], ram[63]);
      end
      we0 = we_count;
      send_frame('{});
      tick();
      tick();
      checks++;
      if ({cpu_reset, done, error} !== 3'b010 || we_count !== we0) begin
         errors++;
         $display("FAIL empty_frame: {cpu_reset,done,error}=%b writes=%0d, required 010 0",
                  {cpu_reset, done, error}, we_count - we0);
      end
   endtask

   task automatic test_garbage();
      logic [7:0] junk [3];
      junk = '{8'h00, 8'hFF, 8'h5A};
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      ram[0] = 32'hDEADBEEF;
      ram[1] = 32'hDEADBEEF;
      stream_gap = 1'b1;
      foreach (junk[i]) send_byte(junk[i]);
      checks++;
      if ({cpu_reset, done, error} !== 3'b100) begin
         errors++;
         $display("FAIL garbage_ignored: {cpu_reset,done,error}=%b, required 100", {cpu_reset, done, error});
      end
      send_frame('{32'hE3A00003, 32'hE2801004});
      stream_gap = 1'b0;
      tick();
      tick();
      checks++;
      if ({cpu_reset, done} !== 2'b01 || ram[0] !== 32'hE3A00003 || ram[1] !== 32'hE2801004) begin
         errors++;
         $display("FAIL garbage_load: {cpu_reset,done}=%b ram0=%h ram1=%h, required 01 e3a00003 e2801004",
                  {cpu_reset, done}, ram[0], ram[1]);
      end
      send_byte(8'h00);
      send_byte(8'h5A);
      tick();
      checks++;
      if ({cpu_reset, done, error} !== 3'b010) begin
         errors++;
         $display("FAIL run_discard: {cpu_reset,done,error}=%b, required 010", {cpu_reset, done, error});
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] part [9];
      part = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      ram[0] = 32'hDEADBEEF;
      ram[1] = 32'hDEADBEEF;
      foreach (part[i]) send_byte(part[i]);
      reset = 1'b0;
      tick();
      checks++;
      if ({in_ready, imem_we, imem_addr, imem_wd, cpu_reset, done, error} !==
          {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL midframe_reset_values: rdy=%b we=%b addr=%0d wd=%h cpu_reset=%b done=%b error=%b, required 0 0 0 0 1 0 0",
                  in_ready, imem_we, imem_addr, imem_wd, cpu_reset, done, error);
      end
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (ram[0] !== 32'h44332211 || ram[1] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL midframe_ram: ram0=%h ram1=%h, required 44332211 deadbeef", ram[0], ram[1]);
      end
   endtask

   task automatic test_restart();
      send_frame('{32'hE3A00003, 32'hE2801004});
      tick();
      tick();
      send_byte(8'hA5);
      checks++;
      if ({cpu_reset, done} !== 2'b01) begin
         errors++;
         $display("FAIL restart_edge0: {cpu_reset,done}=%b, required 01", {cpu_reset, done});
      end
      tick();
      checks++;
      if ({cpu_reset, done} !== 2'b10) begin
         errors++;
         $display("FAIL restart_edge1: {cpu_reset,done}=%b, required 10", {cpu_reset, done});
      end
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h78);
      send_byte(8'h56);
      send_byte(8'h34);
      send_byte(8'h12);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h08);
`endif
      tick();
      tick();
      checks++;
      if ({cpu_reset, done, error} !== 3'b010 || ram[0] !== 32'h12345678 || ram[1] !== 32'hE2801004) begin
         errors++;
         $display("FAIL restart_reload: {cpu_reset,done,error}=%b ram0=%h ram1=%h, required 010 12345678 e2801004",
                  {cpu_reset, done, error}, ram[0], ram[1]);
      end
   endtask

   initial begin
      test_reset();
      test_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_bad_checksum();
`endif
      test_count_bounds();
      test_garbage();
      test_reset_mid_frame();
      test_restart();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the instruction memory of the single-cycle ARM core. Accepts a framed byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words, and writes them into the instruction RAM write port. Holds the core in reset (`cpu_reset`) while loading and releases it only after a complete, well-formed frame has been written.

## Interface
Parameters:
- `ADDR_W`, default 6: word-address width of instruction RAM (64 words).
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  byte-stream source has a byte.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  loader accepts byte; a byte transfers on an edge where `in_valid & in_ready`.
- `imem_we`  out  1  instruction RAM write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wd`  out  32  instruction word.
- `cpu_reset`  out  1  active-high reset to the core; 1 = core held.
- `done`  out  1  last frame loaded successfully; core running.
- `error`  out  1  last frame rejected.

## Operation
- Frame: SYNC_BYTE, count lo, count hi (16-bit word count N), 4·N data bytes (each word b0..b3, word = {b3,b2,b1,b0}), then checksum byte (see Configuration).
- States: IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERR.
- IDLE: discard bytes until SYNC_BYTE → LEN0.
- LEN0 → LEN1 capturing count[7:0]; LEN1 captures count[15:8], then:
  - N > 2^ADDR_W → ERR.
  - N == 0 → CSUM (or RUN-release sequence if checksum compiled out).
  - else → DATA, word index 0, byte index 0.
- DATA: byte index 0..3 wraps; on 4th byte issue write of the assembled word at the current word index, increment index; after word N-1 → CSUM.
- CSUM: checksum byte equal to running XOR of all data bytes → RUN; mismatch → ERR. Count bytes are not in the checksum.
- RUN: `done`=1, `cpu_reset`=0. A SYNC_BYTE restarts: → LEN0, `done`→0, `cpu_reset`→1. Other bytes discarded.
- ERR: `error`=1, `cpu_reset`=1. SYNC_BYTE → LEN0, clears `error`. Other bytes discarded.
- Words beyond N are not written; RAM contents above N are untouched.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wd`=0, `cpu_reset`=1, `done`=0, `error`=0, XOR and counters cleared. Reset mid-frame aborts the frame; partially written words remain in RAM.
- `in_ready`=1 in every state once out of reset; no back-pressure otherwise. Byte consumed in the same edge as the handshake.
- Write latency: `imem_we`/`imem_addr`/`imem_wd` registered, valid for exactly one cycle starting the cycle after the edge accepting byte b3.
- Release: `cpu_reset` falls on the second rising edge after the handshake of the final frame byte; `done` rises on the same edge. Guarantees the last RAM write completes before the core fetches PC 0.
- Entry to ERR: `error` rises the cycle after the offending byte's handshake.
- Restart from RUN: `cpu_reset` rises on the edge after the SYNC_BYTE handshake.
- Word index is ADDR_W+1 bits internally; never wraps because N ≤ 2^ADDR_W is enforced.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: CSUM state, checksum byte required and verified as above.
- Not defined: no checksum byte, no CSUM state, no XOR register; after word N-1 (or N==0) go directly to release; ERR reachable only by oversize count.

## Structure
- Package `imem_loader_pkg`: state enum type, `SYNC_BYTE` default constant, frame-length field width (16).
- One sub-module `word_assembler`: byte index counter, 4-byte shift/assembly, emits word-complete pulse and word; cleared on frame start.

## Test plan
- Frame A5,02,00, 03 00 A0 E3, 04 10 80 E2, csum 0x33^... (XOR of 8 bytes) → writes 0xE3A00003 @0, 0xE2801004 @1; `cpu_reset` falls 2 edges after csum; `done`=1.
- Same frame with checksum byte inverted → no release, `error`=1, `cpu_reset`=1; then valid frame → `error`=0, `done`=1.
- Count 0x0041 (65) with ADDR_W=6 → ERR after count hi byte; zero `imem_we` pulses.
- Garbage bytes 00,FF,5A before A5, `in_valid` toggling every cycle → garbage ignored, load identical to scenario 1.
- `reset`=0 asserted after 6 data bytes → all outputs at reset values next cycle; word 0 written, word 1 not.
- In RUN, send A5 → `cpu_reset`=1 and `done`=0 on next edge; new 1-word frame reloads address 0.
